jam_cost_server: RTL and testbench
==================================

Name: jam_cost_server

Overview:
Responder end of the JAM worker/job cost interface. It holds the 8x8 cost table, answers (W,J) lookups with Cost in the same cycle, and controls the JAM engine's reset. It also captures MinCost/MatchCount when the engine raises Valid and measures run length. It is loaded over a valid/ready stream and sits between the cost-table source (testbench or host loader) and the JAM engine.

Parameters:
COST_W, 7, width of one cost entry and of ld_data/Cost
TIMEOUT, 500000, run cycles allowed before the run is aborted; must be < 2^20
CNT_W, 20, width of the run-cycle counter

Ports:
CLK  in  1  clock
RST  in  1  reset
ld_valid  in  1  load entry present
ld_ready  out  1  block accepts a load entry
ld_data  in  COST_W  cost entry, row-major order (index = W*8+J)
W  in  3  worker index from the JAM engine
J  in  3  job index from the JAM engine
Cost  out  COST_W  table[W][J]
Valid  in  1  JAM result valid
MatchCount  in  4  JAM match count
MinCost  in  10  JAM minimum cost
jam_rst  out  1  sync active-high reset driven to the JAM engine
rerun  in  1  restart a run with the current table
done  out  1  run finished, either by Valid or by timeout
timeout  out  1  run aborted without Valid
res_mincost  out  10  captured MinCost
res_matchcount  out  4  captured MatchCount
run_cycles  out  CNT_W  cycles spent in RUN

Behaviour:
- Reset: RST is synchronous and active-high, clock CLK. On RST: state=LOAD, load index=0, done=0, timeout=0, res_mincost=0, res_matchcount=0, run_cycles=0. Table RAM is not cleared; it is logically invalid until 64 new entries are loaded.
- States: LOAD, RUN, DONE, TOUT.
- LOAD:
  - ld_ready=1; jam_rst=1.
  - A transfer occurs when ld_valid & ld_ready at a posedge: table[idx] <= ld_data, idx++.
  - The transfer at idx=63 moves the state to RUN at the next edge; idx wraps to 0.
  - Gaps in ld_valid are allowed.
- RUN:
  - ld_ready=0; ld_valid is ignored. jam_rst=0.
  - run_cycles increments by 1 every cycle, starting from 0 on the first RUN cycle.
- Valid sampled 1 in RUN:
  - Next edge: res_mincost<=MinCost, res_matchcount<=MatchCount, run_cycles holds the value it has that cycle (no further increment).
  - done<=1; state->DONE.
- Timeout: if run_cycles==TIMEOUT-1 and Valid=0, then at the next edge timeout<=1, done<=1, state->TOUT, results unchanged.
- Valid and timeout in the same cycle: Valid wins (DONE, timeout=0).
- DONE/TOUT:
  - jam_rst=1; ld_ready=0; outputs are held.
  - rerun=1 -> at the next edge: state RUN, done=0, timeout=0, run_cycles=0. The table is kept and results are held until overwritten.
  - rerun in LOAD or RUN is ignored.
- Cost:
  - Combinational (asynchronous read) of table[{W,J}] while in RUN, so JAM can sample Cost in the same cycle it drives W/J.
  - Cost=0 in all other states.
- Reset mid-load or mid-run: immediate return to LOAD at that edge. jam_rst=1 from the following cycle; partial loads are discarded; a full 64-entry reload is required.
- Arithmetic:
  - run_cycles saturates at 2^CNT_W-1. Unreachable when TIMEOUT < 2^CNT_W.
  - The 64-entry index is 6 bits.

Test Plan:
- Load, gappy valid: stream entry k = k mod 100, with ld_valid low every 3rd cycle -> ld_ready falls the cycle after the 64th transfer; in RUN, W=3,J=5 -> Cost=29; W=7,J=7 -> Cost=63.
- Diagonal table (cost 0 where W==J, 100 elsewhere) with JAM attached -> done=1, timeout=0, res_mincost=0, res_matchcount=1, run_cycles>0; jam_rst=1 in DONE.
- Stubbed engine that never asserts Valid, TIMEOUT=100 -> timeout=1 and done=1 exactly 100 cycles after entering RUN; res_* remain 0.
- After the diagonal run, pulse rerun -> done drops; the second run ends with identical res_mincost/res_matchcount/run_cycles and no reload.
- RST after 30 entries loaded -> ld_ready=1, idx=0; RUN is entered only after 64 further transfers; Cost=0 throughout LOAD.
- Valid asserted in the same cycle run_cycles==TIMEOUT-1 -> state DONE, timeout=0, results captured from that cycle.

Source files
------------

// File: rtl/jam_cost_server.sv
// Responder side of the JAM worker/job cost interface: holds the 8x8 cost table,
// sequences load/run/result phases and drives the JAM engine reset.
module jam_cost_server #(
    parameter int COST_W  = 7,
    parameter int TIMEOUT = 500000,
    parameter int CNT_W   = 20
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [COST_W-1:0] ld_data,
    input  logic [2:0]        W,
    input  logic [2:0]        J,
    output logic [COST_W-1:0] Cost,
    input  logic              Valid,
    input  logic [3:0]        MatchCount,
    input  logic [9:0]        MinCost,
    output logic              jam_rst,
    input  logic              rerun,
    output logic              done,
    output logic              timeout,
    output logic [9:0]        res_mincost,
    output logic [3:0]        res_matchcount,
    output logic [CNT_W-1:0]  run_cycles
);

    typedef enum logic [1:0] {S_LOAD, S_RUN, S_DONE, S_TOUT} state_t;

    localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t             state_reg;
    logic [5:0]         idx_reg;
    logic               ld_ready_reg;
    logic               jam_rst_reg;
    logic               done_reg;
    logic               timeout_reg;
    logic [9:0]         res_mincost_reg;
    logic [3:0]         res_matchcount_reg;
    logic [CNT_W-1:0]   run_cycles_reg;
    logic [COST_W-1:0]  table_mem [64];

    logic load_xfer;
    assign load_xfer = (state_reg == S_LOAD) && ld_valid;

    // Table storage has no reset; contents are meaningful only after a full reload.
    always_ff @(posedge CLK) begin
        if (load_xfer) begin
            table_mem[idx_reg] <= ld_data;
        end
    end

    // Asynchronous read so the engine sees Cost in the same cycle it drives W/J.
    assign Cost = (state_reg == S_RUN) ? table_mem[{W, J}] : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg          <= S_LOAD;
            idx_reg            <= '0;
            ld_ready_reg       <= 1'b1;
            jam_rst_reg        <= 1'b1;
            done_reg           <= 1'b0;
            timeout_reg        <= 1'b0;
            res_mincost_reg    <= '0;
            res_matchcount_reg <= '0;
            run_cycles_reg     <= '0;
        end else begin
            case (state_reg)
                S_LOAD: begin
                    if (ld_valid) begin
                        idx_reg <= idx_reg + 6'd1;
                        if (idx_reg == 6'd63) begin
                            state_reg      <= S_RUN;
                            run_cycles_reg <= '0;
                            ld_ready_reg   <= 1'b0;
                            jam_rst_reg    <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    // Valid takes priority over an expiring timeout in the same cycle.
                    if (Valid) begin
                        res_mincost_reg    <= MinCost;
                        res_matchcount_reg <= MatchCount;
                        done_reg           <= 1'b1;
                        jam_rst_reg        <= 1'b1;
                        state_reg          <= S_DONE;
                    end else if (run_cycles_reg == LAST_CYCLE) begin
                        timeout_reg <= 1'b1;
                        done_reg    <= 1'b1;
                        jam_rst_reg <= 1'b1;
                        state_reg   <= S_TOUT;
                    end else if (run_cycles_reg != CNT_MAX) begin
                        run_cycles_reg <= run_cycles_reg + CNT_W'(1);
                    end
                end
                S_DONE, S_TOUT: begin
                    if (rerun) begin
                        state_reg      <= S_RUN;
                        done_reg       <= 1'b0;
                        timeout_reg    <= 1'b0;
                        run_cycles_reg <= '0;
                        jam_rst_reg    <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= S_LOAD;
                end
            endcase
        end
    end

    assign ld_ready       = ld_ready_reg;
    assign jam_rst        = jam_rst_reg;
    assign done           = done_reg;
    assign timeout        = timeout_reg;
    assign res_mincost    = res_mincost_reg;
    assign res_matchcount = res_matchcount_reg;
    assign run_cycles     = run_cycles_reg;

endmodule

// File: tb/tb_jam_cost_server.sv
// Bench for jam_cost_server: table vectors, stub JAM engine runs and a randomized
// load/run loop checked against a plain array model of the cost table.
module tb_jam_cost_server;

    localparam int COST_W = 7;
    localparam int TO     = 100;
    localparam int CNT_W  = 20;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              ld_valid = 1'b0;
    logic              ld_ready;
    logic [COST_W-1:0] ld_data = '0;
    logic [2:0]        W = '0;
    logic [2:0]        J = '0;
    logic [COST_W-1:0] Cost;
    logic              Valid = 1'b0;
    logic [3:0]        MatchCount = '0;
    logic [9:0]        MinCost = '0;
    logic              jam_rst;
    logic              rerun = 1'b0;
    logic              done;
    logic              timeout;
    logic [9:0]        res_mincost;
    logic [3:0]        res_matchcount;
    logic [CNT_W-1:0]  run_cycles;

    always #5 CLK = ~CLK;

    jam_cost_server #(.COST_W(COST_W), .TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .W(W), .J(J), .Cost(Cost),
        .Valid(Valid), .MatchCount(MatchCount), .MinCost(MinCost),
        .jam_rst(jam_rst), .rerun(rerun), .done(done), .timeout(timeout),
        .res_mincost(res_mincost), .res_matchcount(res_matchcount),
        .run_cycles(run_cycles)
    );

    int n_vec = 0;
    int n_bad = 0;
    int model_tab [64];
    int exp_min = 0;
    int exp_mc  = 0;

    typedef struct {
        int w;
        int j;
        int cost;
    } lk_vec_t;
    lk_vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic lookup_at(input int w, input int j);
        W = 3'(w);
        J = 3'(j);
        #1;
        chk("cost_lookup", 32'(Cost), 32'(model_tab[w * 8 + j]));
    endtask

    task automatic cost_zero();
        W = 3'($urandom);
        J = 3'($urandom);
        #1;
        chk("cost_idle_zero", 32'(Cost), 0);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        cyc();
        chk("rst_ld_ready", 32'(ld_ready), 1);
        chk("rst_jam_rst", 32'(jam_rst), 1);
        chk("rst_done", 32'(done), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_res_mincost", 32'(res_mincost), 0);
        chk("rst_res_matchcount", 32'(res_matchcount), 0);
        chk("rst_run_cycles", 32'(run_cycles), 0);
        cost_zero();
        cyc();
        RST = 1'b0;
        exp_min = 0;
        exp_mc  = 0;
    endtask

    // Streams model_tab[0..n-1]; the 64th transfer must be the one that enters RUN.
    task automatic load_n(input int n, input bit gappy);
        int k = 0;
        int c = 0;
        while (k < n) begin
            chk("load_ld_ready", 32'(ld_ready), 1);
            chk("load_jam_rst", 32'(jam_rst), 1);
            cost_zero();
            ld_valid = !(gappy && (c % 3 == 2));
            ld_data  = ld_valid ? COST_W'(model_tab[k]) : COST_W'($urandom);
            rerun    = ($urandom_range(0, 3) == 0);
            cyc();
            if (ld_valid) k++;
            c++;
        end
        ld_valid = 1'b0;
        rerun    = 1'b0;
        if (n == 64) begin
            chk("run_ld_ready", 32'(ld_ready), 0);
            chk("run_jam_rst", 32'(jam_rst), 0);
            chk("run_done", 32'(done), 0);
            chk("run_cycles_first", 32'(run_cycles), 0);
        end else begin
            chk("partial_ld_ready", 32'(ld_ready), 1);
        end
    endtask

    // Stub JAM engine: raises Valid when run_cycles reaches d (d >= TO means never).
    task automatic do_run(input int start, input int d, input int m, input int c,
                          input bit noise, input bit scan);
        int limit;
        bit to_exp;
        limit  = (d < TO) ? d : TO;
        to_exp = (d >= TO);
        for (int i = start; i < limit; i++) begin
            chk("run_cycles_count", 32'(run_cycles), 32'(i));
            chk("done_in_run", 32'(done), 0);
            chk("timeout_in_run", 32'(timeout), 0);
            chk("jam_rst_in_run", 32'(jam_rst), 0);
            MinCost    = 10'($urandom);
            MatchCount = 4'($urandom);
            if (noise) begin
                ld_valid = 1'($urandom_range(0, 1));
                ld_data  = COST_W'($urandom);
                rerun    = ($urandom_range(0, 3) == 0);
            end
            if (scan) lookup_at((i % 64) / 8, i % 8);
            else      lookup_at($urandom_range(0, 7), $urandom_range(0, 7));
            cyc();
        end
        ld_valid = 1'b0;
        rerun    = 1'b0;
        if (!to_exp) begin
            chk("run_cycles_at_valid", 32'(run_cycles), 32'(d));
            Valid      = 1'b1;
            MinCost    = 10'(m);
            MatchCount = 4'(c);
            lookup_at($urandom_range(0, 7), $urandom_range(0, 7));
            cyc();
            Valid      = 1'b0;
            MinCost    = 10'($urandom);
            MatchCount = 4'($urandom);
            exp_min    = m;
            exp_mc     = c;
        end
        for (int h = 0; h < 2; h++) begin
            chk("end_done", 32'(done), 1);
            chk("end_timeout", 32'(timeout), 32'(to_exp));
            chk("end_res_mincost", 32'(res_mincost), 32'(exp_min));
            chk("end_res_matchcount", 32'(res_matchcount), 32'(exp_mc));
            if (!to_exp) chk("end_run_cycles", 32'(run_cycles), 32'(d));
            chk("end_jam_rst", 32'(jam_rst), 1);
            chk("end_ld_ready", 32'(ld_ready), 0);
            cost_zero();
            cyc();
        end
        $display("run: delay=%0d timeout=%0d res_mincost=%0d res_matchcount=%0d run_cycles=%0d",
                 d, timeout, res_mincost, res_matchcount, run_cycles);
    endtask

    task automatic do_rerun();
        rerun = 1'b1;
        cyc();
        rerun = 1'b0;
        chk("rerun_done", 32'(done), 0);
        chk("rerun_timeout", 32'(timeout), 0);
        chk("rerun_run_cycles", 32'(run_cycles), 0);
        chk("rerun_jam_rst", 32'(jam_rst), 0);
    endtask

    task automatic rand_table();
        for (int k = 0; k < 64; k++) model_tab[k] = $urandom_range(0, 127);
    endtask

    initial begin
        vecs[0] = '{3, 5, 29};
        vecs[1] = '{7, 7, 63};
        vecs[2] = '{0, 0, 0};
        vecs[3] = '{0, 7, 7};
        vecs[4] = '{7, 0, 56};
        vecs[5] = '{4, 4, 36};
        vecs[6] = '{2, 6, 22};
        vecs[7] = '{6, 1, 49};

        cyc();
        do_reset();

        // Gappy load of k mod 100, fixed lookups, then a run that never sees Valid.
        for (int k = 0; k < 64; k++) model_tab[k] = k % 100;
        load_n(64, 1'b1);
        for (int v = 0; v < 8; v++) begin
            chk("vec_run_cycles", 32'(run_cycles), 32'(v));
            W = 3'(vecs[v].w);
            J = 3'(vecs[v].j);
            #1;
            chk("vec_cost", 32'(Cost), 32'(vecs[v].cost));
            cyc();
        end
        do_run(8, TO, 0, 0, 1'b1, 1'b0);

        do_rerun();
        do_run(0, $urandom_range(0, 98), $urandom_range(0, 1023), $urandom_range(0, 15), 1'b1, 1'b0);

        // Valid on the very cycle the timeout would fire.
        do_rerun();
        do_run(0, TO - 1, 517, 9, 1'b1, 1'b0);

        // Diagonal table, scanning engine, then a rerun without reload.
        do_reset();
        for (int k = 0; k < 64; k++) model_tab[k] = ((k / 8) == (k % 8)) ? 0 : 100;
        load_n(64, 1'b0);
        do_run(0, 64, 0, 1, 1'b0, 1'b1);
        do_rerun();
        do_run(0, 64, 0, 1, 1'b0, 1'b1);
        do_rerun();
        do_run(0, TO, 0, 0, 1'b1, 1'b0);

        // Reset after a partial load discards it; the full reload defines the table.
        do_reset();
        rand_table();
        load_n(30, 1'b1);
        do_reset();
        rand_table();
        load_n(64, 1'b1);
        do_run(0, $urandom_range(0, 98), $urandom_range(0, 1023), $urandom_range(0, 15), 1'b1, 1'b0);

        // Reset in the middle of a run.
        do_rerun();
        for (int i = 0; i < 5; i++) cyc();
        do_reset();

        for (int it = 0; it < 6; it++) begin
            if (it > 0 && $urandom_range(0, 2) == 0) begin
                do_rerun();
            end else begin
                do_reset();
                rand_table();
                load_n(64, 1'($urandom_range(0, 1)));
            end
            do_run(0, $urandom_range(0, 120), $urandom_range(0, 1023), $urandom_range(0, 15),
                   1'b1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
